// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes rx, finds the start bit, samples each
// bit at its centre and writes complete frames into a downstream rx_fifo.
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8
) (
  input  logic                 pclk,
  input  logic                 Reset,
  input  logic                 rx,
  input  logic                 fifo_full,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_push,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_IDX  = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_q;

  // Handshake: rx_push is a single-cycle strobe with rx_data valid in the same
  // cycle; there is no ready, fifo_full only decides between push and overrun.
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_push     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      rx_push     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          // Sampling one full bit after mid-start lands in the middle of each data bit.
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else if (fifo_full) begin
              overrun_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              rx_data <= shift_q;
              rx_push <= 1'b1;
              state   <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 16 clocks per bit: good frames, latency,
// back-to-back start, glitch, framing error/break, overrun and mid-frame reset.
module tb_uart_rx_deser;

  localparam int CPB = 16;
  // 2 synchronizer cycles + (DATA_BITS+1)*CPB + CPB/2 + 1
  localparam int LAT = 2 + 9 * 16 + 8 + 1;

  logic       pclk;
  logic       reset;
  logic       rx;
  logic       fifo_full;
  logic [7:0] rx_data;
  logic       rx_push;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int push_cnt = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int excl_viol = 0;
  int cur_pulses;
  logic prev_any = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_cyc_q[$];
  int         got_cyc_q[$];

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .pclk       (pclk),
    .Reset      (reset),
    .rx         (rx),
    .fifo_full  (fifo_full),
    .rx_data    (rx_data),
    .rx_push    (rx_push),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // output monitor
  always @(negedge pclk) begin
    if (!reset) begin
      if (rx_push) begin
        got_q.push_back(rx_data);
        got_cyc_q.push_back(cyc);
        push_cnt = push_cnt + 1;
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (overrun_err) ov_cnt = ov_cnt + 1;
      cur_pulses = int'(rx_push) + int'(frame_err) + int'(overrun_err);
      if (cur_pulses > 1 || (cur_pulses > 0 && prev_any)) excl_viol = excl_viol + 1;
      prev_any = (cur_pulses > 0);
    end else begin
      prev_any = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic drive_level(input logic v, input int n);
    rx = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                            output int start_cyc);
    start_cyc = cyc;
    drive_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_level(d[i], CPB);
    drive_level(stop_v, stop_len);
  endtask

  task automatic send_good(input logic [7:0] d, input int stop_len);
    int s;
    send_frame(d, 1'b1, stop_len, s);
    exp_q.push_back(d);
    exp_cyc_q.push_back(s + LAT);
  endtask

  initial begin
    int s;
    logic [7:0] e, g;
    int ec, gc;
    reset = 1'b1;
    rx = 1'b1;
    fifo_full = 1'b0;
    tick(3);
    check("reset_rx_data", rx_data, 0);
    check("reset_pulses", {rx_push, frame_err, overrun_err}, 0);
    check("reset_busy", busy, 0);
    check("reset_state", dbg_state, 0);
    reset = 1'b0;
    tick(5);

    // back-to-back frames; the 9-cycle stop puts the next start edge in the push cycle
    send_good(8'h55, CPB);
    send_good(8'hCC, 9);
    check("hold_between_pushes", rx_data, 8'h55);
    check("busy_in_frame", busy, 1);
    send_good(8'h81, CPB);
    tick(20);
    check("push_count_3", push_cnt, 3);
    check("last_data_81", rx_data, 8'h81);
    check("no_err_good", fe_cnt + ov_cnt, 0);
    check("idle_after_frames", dbg_state, 0);

    // start-bit glitch
    rx = 1'b0;
    tick(4);
    check("glitch_busy", busy, 1);
    tick(1);
    rx = 1'b1;
    tick(30);
    check("glitch_state_idle", dbg_state, 0);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_push", push_cnt, 3);
    check("glitch_no_err", fe_cnt + ov_cnt, 0);
    check("glitch_data_kept", rx_data, 8'h81);

    // framing error then break of 100 cycles
    send_frame(8'hA5, 1'b0, CPB + 100, s);
    check("break_state", dbg_state, 4);
    check("frame_err_once", fe_cnt, 1);
    check("frame_err_no_push", push_cnt, 3);
    check("frame_err_data_kept", rx_data, 8'h81);
    rx = 1'b1;
    tick(5);
    check("break_exit_idle", dbg_state, 0);
    send_good(8'h3C, CPB);
    tick(10);
    check("after_break_data", rx_data, 8'h3C);
    check("frame_err_still_once", fe_cnt, 1);

    // overrun
    fifo_full = 1'b1;
    send_frame(8'h7E, 1'b1, CPB, s);
    tick(5);
    fifo_full = 1'b0;
    check("overrun_once", ov_cnt, 1);
    check("overrun_no_push", push_cnt, 4);
    check("overrun_data_kept", rx_data, 8'h3C);

    // reset after the 4th data bit of 8'hFF
    drive_level(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_level(1'b1, CPB);
    check("mid_frame_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("async_reset_data", rx_data, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_state", dbg_state, 0);
    tick(3);
    reset = 1'b0;
    tick(100);
    check("aborted_no_push", push_cnt, 4);
    check("aborted_no_err", fe_cnt + ov_cnt, 1 + 1);
    send_good(8'h12, CPB);
    tick(10);
    check("after_reset_data", rx_data, 8'h12);

    // scoreboard drain: data and push latency
    check("push_total", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        gc = got_cyc_q.pop_front();
      end else begin
        g = 8'hxx;
        gc = -1;
      end
      check("sb_data", g, e);
      check("sb_latency", gc, ec);
    end
    check("pulse_exclusive", excl_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
